sad_disparity_engine: RTL and testbench
=======================================

// Module: sad_disparity_engine
// PURPOSE
//  Parametrised successor to the single-mode disparity search in the stereo top level.
//  Reads one strip of pixels from each camera's calc RAM (f = right, g = left).
//  Sweeps disparity 0..lim, computing the sum of absolute differences (SAD) over WIN_LEN pixels.
//  Reports the disparity with minimum SAD to the distance/BCD path.
//  Adds runtime disparity limit, shift direction, start/done handshake and SAD output.
// PARAMETERS
//  PIX_W    3     pixel width, bits
//  ADDR_W   11    calc RAM address width
//  WIN_LEN  64    pixels compared per disparity (power of 2, >=2)
//  MAX_DISP 63    largest disparity searched
//  DISP_W   6     disparity width, >= clog2(MAX_DISP+1)
//  SAD_W    PIX_W+clog2(WIN_LEN)  accumulator width (cannot overflow)
// PORTS
//  clk        in   1       calc clock (same clock as calc RAM read ports)
//  rst        in   1       asynchronous reset, active-high
//  start      in   1       one-cycle request; sampled only in IDLE
//  base_addr  in   ADDR_W  first f address of the window
//  disp_lim   in   DISP_W  last disparity to test; values > MAX_DISP clamp to MAX_DISP
//  dir        in   1       0: g addr = f addr + d; 1: g addr = f addr - d
//  address_f  out  ADDR_W  f RAM read address
//  address_g  out  ADDR_W  g RAM read address
//  rden       out  1       high while addresses are valid
//  fdata      in   PIX_W   f RAM q, 1 cycle after address (registered address)
//  gdata      in   PIX_W   g RAM q, 1 cycle after address
//  busy       out  1       high from the cycle after start until done
//  done       out  1       one-cycle pulse when result updates
//  disp       out  DISP_W  best disparity, held until next done
//  sad_min    out  SAD_W   SAD at disp, held until next done
// BEHAVIOUR
//  - Reset: address_f/g=0, rden=0, busy=0, done=0, disp=0, sad_min=0, FSM=IDLE.
//  - Start latching: start, base_addr, disp_lim and dir are latched on the edge where start=1 in IDLE.
//    That edge is cycle 0. start while busy or DONE is ignored.
//  - FSM states and transitions:
//    - IDLE -> RUN on start.
//    - RUN -> DRAIN after the last address is issued.
//    - DRAIN -> DONE when the last compare is complete.
//    - DONE -> IDLE after one cycle.
//  - RUN issues one address pair per cycle, with no gaps:
//    - Order: d=0..L (L = clamped lim), then i=0..WIN_LEN-1 within each d.
//    - address_f = base+i.
//    - address_g = base+i+d (dir=0) or base+i-d (dir=1).
//    - All address arithmetic is modulo 2^ADDR_W, with silent wrap.
//    - rden=1 exactly in RUN.
//    - N = (L+1)*WIN_LEN address cycles, in cycles 1..N.
//  - Data pipeline:
//    - d, first and last tags travel in a 2-stage pipe alongside the address.
//    - Data for issue n is accumulated at the end of cycle n+2.
//    - The first sample of each d overwrites the accumulator; later samples add |f-g|.
//  - Compare (end of cycle after the last sample of each d):
//    - Replace best if d==0 or acc < best_sad (strict).
//    - Ties keep the smaller d.
//  - Result: done=1 and disp/sad_min are updated in cycle N+4; busy falls in the same cycle.
//    - L=0 gives N=WIN_LEN: a valid single-disparity search.
//  - Mid-operation events:
//    - rst at any time aborts the search: all state returns to reset values.
//    - No partial result is published.
//    - Input changes after cycle 0 have no effect on the running search.
// STRUCTURE
//  - stereo_pkg holds shared items:
//    - state enum IDLE/RUN/DRAIN/DONE.
//    - default PIX_W/ADDR_W/DISP_W constants.
//    - clog2 function, shared with cam2ram and dist2bcd blocks.
//  - One sub-module, sad_accum, contains the tagged |f-g| accumulate stage.
//    - Inputs: clk, rst, valid, first, fdata, gdata. Output: acc.
//  - The top level holds the FSM, address counters, tag pipe and best-of compare.
// TESTING (bench models two 2048x3 registered-address RAMs)
//  - g==f everywhere, base=0, lim=63, dir=0 -> disp=0, sad_min=0, done at cycle 64*64+4=4100.
//  - g[k+5]=f[k], random f, lim=63 -> disp=5, sad_min=0; rden high exactly 4096 cycles.
//  - Constant f=3, g=3 except a 1 at g[10]; lim=2 -> all SADs 2, tie -> disp=0, sad_min=2.
//  - dir=1, g[k-7]=f[k], base=2040 (wrap) -> addresses wrap past 2047, disp=7; lim=70 clamps to 63.
//  - start pulsed again mid-RUN -> ignored, single done; rst at cycle 100 -> outputs 0, no done.
//  - lim=0, WIN_LEN=64, |f-g|=7 at all pixels -> disp=0, sad_min=448, done at cycle 68.

Source files
------------

// File: rtl/stereo_pkg.sv
// Shared stereo-path items: search FSM states, default widths and clog2.
package stereo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned DEF_PIX_W    = 3;
  localparam int unsigned DEF_ADDR_W   = 11;
  localparam int unsigned DEF_DISP_W   = 6;
  localparam int unsigned DEF_WIN_LEN  = 64;
  localparam int unsigned DEF_MAX_DISP = 63;

  // Ceiling log2, usable in constant expressions (clog2(1) = 0).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned k = 0; k < 32; k++) begin
      if ((64'd1 << k) < 64'(value)) r = k + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sad_accum.sv
// Tagged |f-g| accumulate stage: registers the absolute difference, then
// either restarts (first sample of a disparity) or adds into the sum.
module sad_accum
  import stereo_pkg::*;
#(
  parameter int unsigned PIX_W = DEF_PIX_W,
  parameter int unsigned SAD_W = DEF_PIX_W + clog2(DEF_WIN_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic             first,
  input  logic [PIX_W-1:0] fdata,
  input  logic [PIX_W-1:0] gdata,
  output logic [SAD_W-1:0] acc
);

  logic [PIX_W-1:0] diff_c;
  logic [PIX_W-1:0] diff_q;
  logic             valid_q;
  logic             first_q;

  // Absolute difference of the two pixels presented this cycle.
  always_comb begin
    diff_c = (fdata >= gdata) ? (fdata - gdata) : (gdata - fdata);
  end

  // Difference register followed by the overwrite-or-add accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff_q  <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      acc     <= '0;
    end else begin
      diff_q  <= diff_c;
      valid_q <= valid;
      first_q <= first;
      if (valid_q) begin
        if (first_q) acc <= SAD_W'(diff_q);
        else         acc <= acc + SAD_W'(diff_q);
      end
    end
  end

endmodule

// File: rtl/sad_disparity_engine.sv
// SAD disparity search: sweeps d = 0..lim over a WIN_LEN strip of the f/g
// calc RAMs, accumulates |f-g| per disparity and reports the minimum.
module sad_disparity_engine
  import stereo_pkg::*;
#(
  parameter int unsigned PIX_W    = DEF_PIX_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned WIN_LEN  = DEF_WIN_LEN,
  parameter int unsigned MAX_DISP = DEF_MAX_DISP,
  parameter int unsigned DISP_W   = DEF_DISP_W,
  parameter int unsigned SAD_W    = PIX_W + clog2(WIN_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DISP_W-1:0] disp_lim,
  input  logic              dir,
  output logic [ADDR_W-1:0] address_f,
  output logic [ADDR_W-1:0] address_g,
  output logic              rden,
  input  logic [PIX_W-1:0]  fdata,
  input  logic [PIX_W-1:0]  gdata,
  output logic              busy,
  output logic              done,
  output logic [DISP_W-1:0] disp,
  output logic [SAD_W-1:0]  sad_min
);

  localparam int unsigned IDX_W = clog2(WIN_LEN);
  localparam logic [IDX_W-1:0] I_LAST = IDX_W'(WIN_LEN - 1);

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [DISP_W-1:0] lim_q;
  logic              dir_q;
  logic [IDX_W-1:0]  i_cnt;
  logic [DISP_W-1:0] d_cnt;

  logic [DISP_W-1:0] lim_clamped_c;
  logic [DISP_W-1:0] d_next_c;
  logic              last_issue_c;

  // Tag pipe: stage 1 lines up with RAM q, stage 2 with the accumulate edge.
  logic              v1, f1, l1;
  logic [DISP_W-1:0] d1;
  logic              v2, l2;
  logic [DISP_W-1:0] d2;

  // Compare stage: one cycle after the last sample of a disparity.
  logic              cmp_go;
  logic [DISP_W-1:0] cmp_d;
  logic [SAD_W-1:0]  acc;
  logic [SAD_W-1:0]  best_sad;
  logic [DISP_W-1:0] best_d;
  logic              take_c;
  logic              final_c;

  // Limit clamp, next-disparity value and end-of-sweep detect.
  always_comb begin
    lim_clamped_c = disp_lim;
    if (32'(disp_lim) > MAX_DISP) lim_clamped_c = DISP_W'(MAX_DISP);
    d_next_c     = d_cnt + DISP_W'(1);
    last_issue_c = (i_cnt == I_LAST) && (d_cnt == lim_q);
  end

  // Best-of decision: d==0 seeds the best, later disparities must be strictly lower.
  always_comb begin
    take_c  = (cmp_d == '0) || (acc < best_sad);
    final_c = cmp_go && (cmp_d == lim_q);
  end

  // Search FSM with address generation; all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      base_q    <= '0;
      lim_q     <= '0;
      dir_q     <= 1'b0;
      i_cnt     <= '0;
      d_cnt     <= '0;
      address_f <= '0;
      address_g <= '0;
      rden      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_q    <= base_addr;
            lim_q     <= lim_clamped_c;
            dir_q     <= dir;
            i_cnt     <= '0;
            d_cnt     <= '0;
            address_f <= base_addr;
            address_g <= base_addr;
            rden      <= 1'b1;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (last_issue_c) begin
            rden  <= 1'b0;
            state <= DRAIN;
          end else if (i_cnt == I_LAST) begin
            i_cnt     <= '0;
            d_cnt     <= d_next_c;
            address_f <= base_q;
            address_g <= dir_q ? (base_q - ADDR_W'(d_next_c))
                               : (base_q + ADDR_W'(d_next_c));
          end else begin
            i_cnt     <= i_cnt + IDX_W'(1);
            address_f <= address_f + ADDR_W'(1);
            address_g <= address_g + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (final_c) begin
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Two-stage tag pipe carrying valid/first/last/d alongside the RAM read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1     <= 1'b0;
      f1     <= 1'b0;
      l1     <= 1'b0;
      d1     <= '0;
      v2     <= 1'b0;
      l2     <= 1'b0;
      d2     <= '0;
      cmp_go <= 1'b0;
      cmp_d  <= '0;
    end else begin
      v1     <= rden;
      f1     <= (i_cnt == '0);
      l1     <= (i_cnt == I_LAST);
      d1     <= d_cnt;
      v2     <= v1;
      l2     <= l1;
      d2     <= d1;
      cmp_go <= v2 && l2;
      cmp_d  <= d2;
    end
  end

  sad_accum #(
    .PIX_W (PIX_W),
    .SAD_W (SAD_W)
  ) u_sad_accum (
    .clk   (clk),
    .rst   (rst),
    .valid (v1),
    .first (f1),
    .fdata (fdata),
    .gdata (gdata),
    .acc   (acc)
  );

  // Running best and result publication on the final compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_sad <= '0;
      best_d   <= '0;
      disp     <= '0;
      sad_min  <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cmp_go) begin
        if (take_c) begin
          best_sad <= acc;
          best_d   <= cmp_d;
        end
        if (final_c) begin
          done    <= 1'b1;
          disp    <= take_c ? cmp_d : best_d;
          sad_min <= take_c ? acc : best_sad;
        end
      end
    end
  end

endmodule

// File: tb/tb_sad_disparity_engine.sv
// Scoreboard bench for sad_disparity_engine with two registered-address
// 2048x3 calc RAM models.
module tb_sad_disparity_engine;

  localparam int unsigned PIX_W    = 3;
  localparam int unsigned ADDR_W   = 11;
  localparam int unsigned WIN_LEN  = 64;
  localparam int unsigned MAX_DISP = 63;
  localparam int unsigned DISP_W   = 7;
  localparam int unsigned SAD_W    = 9;
  localparam int          RAM_D    = 2048;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [DISP_W-1:0] disp_lim = '0;
  logic              dir = 1'b0;
  logic [ADDR_W-1:0] address_f, address_g;
  logic              rden, busy, done;
  logic [PIX_W-1:0]  fdata, gdata;
  logic [DISP_W-1:0] disp;
  logic [SAD_W-1:0]  sad_min;

  logic [PIX_W-1:0] ram_f [RAM_D];
  logic [PIX_W-1:0] ram_g [RAM_D];

  int vectors = 0;
  int miscompares = 0;
  int edge_cnt = 0;

  typedef struct {
    logic [DISP_W-1:0] disp;
    logic [SAD_W-1:0]  sad;
    int                edge_n;
  } exp_t;
  exp_t exp_q[$];

  // Trace state of the search under observation.
  bit                tr_on = 1'b0;
  int                start_edge = 0;
  int                tr_n = 0;
  logic [ADDR_W-1:0] tr_base = '0;
  bit                tr_dir = 1'b0;
  int                tr_err = 0;
  int                tr_first_bad = 0;
  int                rden_cnt = 0;

  sad_disparity_engine #(
    .PIX_W    (PIX_W),
    .ADDR_W   (ADDR_W),
    .WIN_LEN  (WIN_LEN),
    .MAX_DISP (MAX_DISP),
    .DISP_W   (DISP_W),
    .SAD_W    (SAD_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .disp_lim  (disp_lim),
    .dir       (dir),
    .address_f (address_f),
    .address_g (address_g),
    .rden      (rden),
    .fdata     (fdata),
    .gdata     (gdata),
    .busy      (busy),
    .done      (done),
    .disp      (disp),
    .sad_min   (sad_min)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Registered-address RAMs: q follows the address by one cycle.
  always @(posedge clk) begin
    fdata <= ram_f[address_f];
    gdata <= ram_g[address_g];
  end

  task automatic check(input string name, input longint act, input longint req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: scoreboard pop on done, plus per-cycle rden/busy/address trace.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: got done with disp=%0d sad_min=%0d, required no done",
                   disp, sad_min);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("done_disp", longint'(disp), longint'(e.disp));
          check("done_sad_min", longint'(sad_min), longint'(e.sad));
          check("done_edge", longint'(edge_cnt), longint'(e.edge_n));
        end
      end
      if (tr_on) begin
        int c, i, d;
        bit exp_r, exp_b, bad;
        logic [ADDR_W-1:0] ef, eg;
        c = edge_cnt - start_edge + 1;
        exp_r = (c >= 1) && (c <= tr_n);
        exp_b = (c >= 1) && (c <= tr_n + 3);
        if (rden) rden_cnt++;
        bad = (rden !== exp_r) || (busy !== exp_b);
        if (exp_r) begin
          i = (c - 1) % WIN_LEN;
          d = (c - 1) / WIN_LEN;
          ef = tr_base + ADDR_W'(i);
          eg = tr_dir ? (ef - ADDR_W'(d)) : (ef + ADDR_W'(d));
          if ((address_f !== ef) || (address_g !== eg)) bad = 1'b1;
        end
        if (bad) begin
          if (tr_err == 0) tr_first_bad = c;
          tr_err++;
        end
      end
    end
  end

  // Issue one search; optionally push its expected result to the scoreboard.
  task automatic launch(input logic [ADDR_W-1:0] b, input logic [DISP_W-1:0] lim,
                        input bit dr, input int n, input bit expect_done,
                        input logic [DISP_W-1:0] ed, input logic [SAD_W-1:0] es);
    @(negedge clk);
    base_addr  = b;
    disp_lim   = lim;
    dir        = dr;
    start      = 1'b1;
    start_edge = edge_cnt + 1;
    tr_base    = b;
    tr_dir     = dr;
    tr_n       = n;
    tr_err     = 0;
    rden_cnt   = 0;
    tr_on      = 1'b1;
    if (expect_done) begin
      exp_t e;
      e.disp   = ed;
      e.sad    = es;
      e.edge_n = start_edge + n + 3;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start     = 1'b0;
    base_addr = b ^ ADDR_W'(11'h555);
    disp_lim  = DISP_W'(1);
    dir       = ~dr;
  endtask

  task automatic wait_cycle(input int c);
    while (edge_cnt - start_edge + 1 < c) @(negedge clk);
  endtask

  task automatic finish_search(input string name, input int n);
    int guard;
    guard = 0;
    while ((exp_q.size() != 0) && (guard < n + 50)) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: no done within %0d cycles, required done", name, guard);
      exp_q.delete();
    end
    repeat (6) @(negedge clk);
    check({name, "_trace_bad_cycles"}, tr_err, 0);
    if (tr_err != 0) $display("  first bad trace cycle %0d", tr_first_bad);
    check({name, "_rden_cycles"}, rden_cnt, n);
    tr_on = 1'b0;
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_address_f"}, address_f, 0);
    check({name, "_address_g"}, address_g, 0);
    check({name, "_rden"}, rden, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    check({name, "_disp"}, disp, 0);
    check({name, "_sad_min"}, sad_min, 0);
  endtask

  initial begin
    int idle_seen;
    for (int k = 0; k < RAM_D; k++) begin
      ram_f[k] = '0;
      ram_g[k] = '0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // g identical to f: every disparity 0..63 searched, d=0 wins at SAD 0.
    for (int k = 0; k < RAM_D; k++) begin
      ram_f[k] = PIX_W'($urandom_range(0, 7));
      ram_g[k] = ram_f[k];
    end
    launch(11'd0, 7'd63, 1'b0, 4096, 1'b1, 7'd0, 9'd0);
    finish_search("t1_equal", 4096);

    // g shifted right by 5: exact match at d=5.
    for (int k = 0; k < RAM_D; k++) ram_f[k] = PIX_W'($urandom_range(0, 7));
    for (int k = 0; k < RAM_D; k++) ram_g[(k + 5) % RAM_D] = ram_f[k];
    launch(11'd0, 7'd63, 1'b0, 4096, 1'b1, 7'd5, 9'd0);
    finish_search("t2_shift5", 4096);

    // Single outlier seen by every disparity: tie at SAD 2 keeps d=0.
    // A second start mid-RUN and one in the DONE cycle must be ignored.
    for (int k = 0; k < RAM_D; k++) begin
      ram_f[k] = 3'd3;
      ram_g[k] = 3'd3;
    end
    ram_g[10] = 3'd1;
    launch(11'd0, 7'd2, 1'b0, 192, 1'b1, 7'd0, 9'd2);
    wait_cycle(50);
    base_addr = 11'd300;
    disp_lim  = 7'd0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cycle(196);
    disp_lim = 7'd0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_search("t3_tie", 192);

    // dir=1 with wrapping addresses from base 2040; limit 70 clamps to 63.
    for (int k = 0; k < RAM_D; k++) ram_f[k] = PIX_W'($urandom_range(0, 7));
    for (int k = 0; k < RAM_D; k++) ram_g[(k + RAM_D - 7) % RAM_D] = ram_f[k];
    launch(11'd2040, 7'd70, 1'b1, 4096, 1'b1, 7'd7, 9'd0);
    finish_search("t4_wrap_clamp", 4096);

    // Reset at cycle 100 aborts the search with no result published.
    launch(11'd0, 7'd63, 1'b0, 4096, 1'b0, 7'd0, 9'd0);
    wait_cycle(100);
    tr_on = 1'b0;
    rst   = 1'b1;
    #1;
    check_zero_outputs("t5_midrst");
    @(negedge clk);
    rst = 1'b0;
    idle_seen = 0;
    repeat (4200) begin
      @(negedge clk);
      if (busy || rden || done) idle_seen++;
    end
    check("t5_activity_after_rst", idle_seen, 0);
    check("t5_disp_after_rst", disp, 0);

    // Single disparity with |f-g|=7 everywhere: SAD 448, done at cycle 68.
    for (int k = 0; k < RAM_D; k++) begin
      ram_f[k] = 3'd7;
      ram_g[k] = 3'd0;
    end
    launch(11'd500, 7'd0, 1'b0, 64, 1'b1, 7'd0, 9'd448);
    finish_search("t6_lim0", 64);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
